controle_desloca_param: RTL and testbench
=========================================

# controle_desloca_param

Parametrised sequencer for the add-and-shift datapath. It is started by a handshake and drives, in order, the operand register enable, the sum register enable, the shift-register load, a runtime-programmable number of shift cycles, and the result register enable. It reports busy/done status, supports a synchronous abort, and has an auto-repeat mode. It sits between the top-level control logic and the A/B, sum, shift and result registers.

## Interface
- CNT_W, default 4: width of the shift-count input and the internal down-counter. Shift count range is 0 to 2^CNT_W-1.
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- repete  in  1  auto-repeat mode; latched together with n_desloca.
- n_desloca  in  CNT_W  number of Desloca cycles for the next operation.
- HabRegAB  out  1  operand register A/B enable.
- HabRegS  out  1  sum register enable.
- LoadDesloca  out  1  shift register parallel load.
- Desloca  out  1  shift enable, high for exactly n cycles.
- HabRegFim  out  1  result register enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, coincident with HabRegFim.
- cnt_restante  out  CNT_W  remaining shift cycles (counter value).

## Operation
- States: IDLE, CARGA_AB, SOMA, CARGA_DESL, DESLOCA, FIM. Encoding is free.
- Outputs are Moore, decoded from the state only. Each state drives only its own signal(s); all others are 0.
- IDLE: all enables 0, busy=0.
  - start=1 → CARGA_AB.
  - On the same edge, latch n_desloca into n_reg and repete into rep_reg.
- CARGA_AB: HabRegAB=1 → SOMA.
- SOMA: HabRegS=1 → CARGA_DESL.
- CARGA_DESL: LoadDesloca=1; counter is loaded with n_reg.
  - n_reg=0 → FIM (shift phase skipped).
  - n_reg≠0 → DESLOCA.
- DESLOCA: Desloca=1; counter decrements by 1 each cycle.
  - counter=1 → FIM (counter becomes 0).
  - Otherwise stay in DESLOCA.
- FIM: HabRegFim=1, done=1.
  - rep_reg=1 → CARGA_AB, re-latching n_desloca and repete on that edge.
  - Otherwise → IDLE.
- abort=1 at any edge in a non-IDLE state → IDLE. The counter is cleared and done does not pulse. Abort has priority over every other transition.
- abort in IDLE has no effect. If start and abort are both 1 in IDLE, abort wins and the block stays in IDLE.
- start in a non-IDLE state is ignored, never queued.
- n_desloca and repete changes during an operation have no effect until the next latch point.
- cnt_restante holds the counter value. It is 0 in IDLE, CARGA_AB, SOMA and FIM after completion. Arithmetic is unsigned CNT_W-bit; the counter never decrements below 0.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, n_reg=0, rep_reg=0.
  - All outputs 0 immediately, without waiting for a clock edge.
- Reset release is synchronous in effect: the first transition occurs on the first rising edge with rst=1.
- Start at edge t0 gives this sequence:
  - HabRegAB in cycle t0→t1.
  - HabRegS in t1→t2.
  - LoadDesloca in t2→t3.
  - Desloca in t3→t3+n.
  - HabRegFim/done in t3+n→t4+n.
  - busy falls at t4+n (non-repeat).
- Total busy time is n+4 cycles; for n=0 it is 4 cycles.
- Repeat mode: no IDLE gap. HabRegAB of the next pass follows HabRegFim in the very next cycle.
- Reset asserted mid-operation: all outputs go to 0 asynchronously, and no done pulse is produced.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0 and cnt_restante=0. Release, start=0 for 5 cycles → outputs stay 0.
- Normal run, CNT_W=4, n_desloca=5, start pulsed 1 cycle:
  - HabRegAB, HabRegS, LoadDesloca each high 1 cycle in order.
  - Desloca high exactly 5 cycles, cnt_restante 5,4,3,2,1.
  - HabRegFim and done 1 cycle; busy high 9 cycles.
- Boundaries: n_desloca=0 → Desloca never asserted, done 4 cycles after start. n_desloca=15 → Desloca high exactly 15 cycles.
- Abort in the 3rd Desloca cycle with n=6 → IDLE next cycle, Desloca drops, no done, cnt_restante=0. A new start then runs a full 10-cycle sequence.
- Repeat: repete=1 with n=2 at start, then n_desloca=3 and repete=0 applied before the first FIM:
  - Pass 1 has 2 Desloca cycles; pass 2 has 3 and then returns to IDLE.
  - Two done pulses, 7 cycles apart.
- Start held high continuously with repete=0 → new operation begins the cycle after FIM→IDLE, i.e. one IDLE cycle between passes. A start asserted mid-operation produces no extra pass.

Source files
------------

// File: rtl/controle_desloca_param.sv
// Sequencer for the add-and-shift datapath: loads operands, sums, loads the
// shift register, shifts a programmable number of cycles, then captures the
// result. Supports synchronous abort and an auto-repeat mode.
module controle_desloca_param #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,          // async, active low
    input  logic             start,
    input  logic             abort,
    input  logic             repete,
    input  logic [CNT_W-1:0] n_desloca,
    output logic             HabRegAB,
    output logic             HabRegS,
    output logic             LoadDesloca,
    output logic             Desloca,
    output logic             HabRegFim,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt_restante
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CARGA_AB   = 3'd1,
        SOMA       = 3'd2,
        CARGA_DESL = 3'd3,
        DESLOCA    = 3'd4,
        FIM        = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;       // shift count latched at start / repeat
    logic             rep_q, rep_d;   // repeat flag latched with n_q
    logic [CNT_W-1:0] cnt_q, cnt_d;   // remaining shift cycles

    // State, latched parameters and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort outranks every other transition outside IDLE
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // start together with abort is dropped: abort wins
                    if (start && !abort) begin
                        state_d = CARGA_AB;
                        n_d     = n_desloca;
                        rep_d   = repete;
                    end
                end
                CARGA_AB:   state_d = SOMA;
                SOMA:       state_d = CARGA_DESL;
                CARGA_DESL: begin
                    cnt_d   = n_q;
                    state_d = (n_q == '0) ? FIM : DESLOCA;
                end
                DESLOCA: begin
                    // never wraps below zero
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) state_d = FIM;
                end
                FIM: begin
                    cnt_d = '0;
                    if (rep_q) begin
                        // back-to-back pass, re-sampling the parameters
                        state_d = CARGA_AB;
                        n_d     = n_desloca;
                        rep_d   = repete;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state only
    assign HabRegAB     = (state_q == CARGA_AB);
    assign HabRegS      = (state_q == SOMA);
    assign LoadDesloca  = (state_q == CARGA_DESL);
    assign Desloca      = (state_q == DESLOCA);
    assign HabRegFim    = (state_q == FIM);
    assign done         = (state_q == FIM);
    assign busy         = (state_q != IDLE);
    assign cnt_restante = cnt_q;

endmodule

// File: tb/tb_controle_desloca_param.sv
module tb_controle_desloca_param;

    localparam int CNT_W = 4;
    localparam int VW    = 7 + CNT_W;

    // expected-trace kinds
    localparam int K_IDLE = 0, K_AB = 1, K_S = 2, K_LD = 3, K_D = 4, K_FIM = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0, abort = 1'b0, repete = 1'b0;
    logic [CNT_W-1:0] n_desloca = '0;
    logic             HabRegAB, HabRegS, LoadDesloca, Desloca, HabRegFim, busy, done;
    logic [CNT_W-1:0] cnt_restante;

    int checks = 0;
    int errors = 0;
    logic [VW-1:0] sb[$];
    logic [VW-1:0] exp_v, obs_v;
    int            cyc_no;

    controle_desloca_param #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .repete(repete),
        .n_desloca(n_desloca), .HabRegAB(HabRegAB), .HabRegS(HabRegS),
        .LoadDesloca(LoadDesloca), .Desloca(Desloca), .HabRegFim(HabRegFim),
        .busy(busy), .done(done), .cnt_restante(cnt_restante)
    );

    always #5 clk = ~clk;

    // observed vector: {busy, AB, S, LD, D, FIM, done, cnt}
    function automatic logic [VW-1:0] obs();
        return {busy, HabRegAB, HabRegS, LoadDesloca, Desloca, HabRegFim, done, cnt_restante};
    endfunction

    // expected vector for one cycle of a given kind
    function automatic logic [VW-1:0] ev(int kind, int cnt);
        logic [CNT_W-1:0] c;
        c = CNT_W'(cnt);
        case (kind)
            K_AB:    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c};
            K_S:     return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c};
            K_LD:    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c};
            K_D:     return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c};
            K_FIM:   return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c};
            default: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c};
        endcase
    endfunction

    // queue the cycle-by-cycle outputs of one pass with shift count n
    task automatic push_pass(input int n);
        sb.push_back(ev(K_AB, 0));
        sb.push_back(ev(K_S, 0));
        sb.push_back(ev(K_LD, 0));
        for (int i = n; i >= 1; i--) sb.push_back(ev(K_D, i));
        sb.push_back(ev(K_FIM, 0));
    endtask

    task automatic push_idle(input int k);
        for (int i = 0; i < k; i++) sb.push_back(ev(K_IDLE, 0));
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); abort = 1'($urandom); repete = 1'($urandom);
            n_desloca = CNT_W'($urandom);
            cyc();
            checks++;
            if (obs() !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs(), {VW{1'b0}});
            end
        end
        start = 0; abort = 0; repete = 0; n_desloca = '0;
        #2 rst = 1'b1;
        push_idle(5);
        cyc_no = 0;
        while (sb.size() > 0) begin
            cyc();
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL reset_release cycle %0d: got %b expected %b", cyc_no, obs(), exp_v);
            end
            cyc_no++;
        end
    endtask

    task automatic test_run(input int n, input string nm);
        start = 1'b1; n_desloca = CNT_W'(n); repete = 1'b0;
        push_pass(n);
        push_idle(2);
        cyc_no = 0;
        while (sb.size() > 0) begin
            cyc();
            start = 1'b0;
            n_desloca = CNT_W'($urandom);   // must not disturb the running pass
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc_no, obs(), exp_v);
            end
            cyc_no++;
        end
    endtask

    task automatic test_abort();
        // start with abort in IDLE: nothing happens
        start = 1'b1; abort = 1'b1; n_desloca = 4'd3;
        push_idle(2);
        while (sb.size() > 0) begin
            cyc();
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL abort_idle: got %b expected %b", obs(), exp_v);
            end
        end
        start = 1'b0; abort = 1'b0;
        cyc();
        // n=6, abort during the third Desloca cycle
        start = 1'b1; n_desloca = 4'd6;
        sb.push_back(ev(K_AB, 0)); sb.push_back(ev(K_S, 0)); sb.push_back(ev(K_LD, 0));
        sb.push_back(ev(K_D, 6)); sb.push_back(ev(K_D, 5)); sb.push_back(ev(K_D, 4));
        cyc_no = 0;
        while (sb.size() > 0) begin
            cyc();
            start = 1'b0;
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: got %b expected %b", cyc_no, obs(), exp_v);
            end
            cyc_no++;
        end
        abort = 1'b1;
        push_idle(1);
        cyc();
        abort = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL abort_exit: got %b expected %b", obs(), exp_v);
        end
        // fresh start afterwards runs the full 10-cycle sequence
        start = 1'b1; n_desloca = 4'd6;
        push_pass(6);
        push_idle(1);
        cyc_no = 0;
        while (sb.size() > 0) begin
            cyc();
            start = 1'b0;
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL abort_rerun cycle %0d: got %b expected %b", cyc_no, obs(), exp_v);
            end
            cyc_no++;
        end
    endtask

    task automatic test_repeat();
        int first_done, second_done;
        first_done = -1; second_done = -1;
        start = 1'b1; n_desloca = 4'd2; repete = 1'b1;
        push_pass(2);
        push_pass(3);
        push_idle(2);
        cyc_no = 0;
        while (sb.size() > 0) begin
            cyc();
            start = 1'b0; n_desloca = 4'd3; repete = 1'b0;
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL repeat cycle %0d: got %b expected %b", cyc_no, obs(), exp_v);
            end
            if (done === 1'b1) begin
                if (first_done < 0) first_done = cyc_no;
                else if (second_done < 0) second_done = cyc_no;
            end
            cyc_no++;
        end
        checks++;
        if (second_done - first_done !== 7) begin
            errors++;
            $display("FAIL repeat_done_gap: got %0d expected 7", second_done - first_done);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; n_desloca = 4'd1; repete = 1'b0;
        push_pass(1);
        push_idle(1);
        push_pass(1);
        cyc_no = 0;
        while (sb.size() > 0) begin
            cyc();
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", cyc_no, obs(), exp_v);
            end
            cyc_no++;
        end
        start = 1'b0;
        push_idle(2);
        while (sb.size() > 0) begin
            cyc();
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL back_to_back_tail: got %b expected %b", obs(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; n_desloca = 4'd4; repete = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc(); cyc();   // now in the first Desloca cycle
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", obs(), {VW{1'b0}});
        end
        cyc();
        rst = 1'b1; repete = 1'b0;
        push_idle(3);
        while (sb.size() > 0) begin
            cyc();
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_after: got %b expected %b", obs(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run(5, "run_n5");
        test_run(0, "run_n0");
        test_run(15, "run_n15");
        test_abort();
        test_repeat();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
